memory_stage_wreg: RTL and testbench

//  Y86-64 memory stage plus W pipeline register; sits directly upstream of write_back.
//  - Performs the data-memory access selected by icode.
//  - Generates the memory status.
//  - Registers {stat, icode, Cnd, rA, rB, valE, valM} into W for write_back.
//  - Exposes combinational m_valM / m_stat for forwarding and hazard control.

---
 rtl/memory_stage_wreg_if.sv | 37 +++
 rtl/memory_stage_wreg.sv | 160 ++++++++++++++++
 tb/tb_memory_stage_wreg.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_wreg_if.sv
// Bundle between the execute-side M register, the hazard unit and write_back:
// M inputs and W controls in, forwarding taps and W register out.
interface memory_stage_wreg_if;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [3:0]  M_rA;
  logic [3:0]  M_rB;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [63:0] M_valP;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic        W_Cnd;
  logic [3:0]  W_rA;
  logic [3:0]  W_rB;
  logic [63:0] W_valE;
  logic [63:0] W_valM;

  modport master (
    output M_stat, M_icode, M_Cnd, M_rA, M_rB, M_valE, M_valA, M_valP,
    output W_stall, W_bubble,
    input  m_valM, m_stat,
    input  W_stat, W_icode, W_Cnd, W_rA, W_rB, W_valE, W_valM
  );

  modport slave (
    input  M_stat, M_icode, M_Cnd, M_rA, M_rB, M_valE, M_valA, M_valP,
    input  W_stall, W_bubble,
    output m_valM, m_stat,
    output W_stat, W_icode, W_Cnd, W_rA, W_rB, W_valE, W_valM
  );
endinterface

// File: rtl/memory_stage_wreg.sv
// Y86-64 memory stage: byte-addressed little-endian data memory access,
// status generation, and the W pipeline register feeding write_back.
module memory_stage_wreg #(
  parameter int MEM_BYTES = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  memory_stage_wreg_if.slave  bus
);

  localparam int          AW         = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);

  typedef enum logic [3:0] {
    STAT_AOK = 4'd1,
    STAT_HLT = 4'd2,
    STAT_ADR = 4'd3,
    STAT_INS = 4'd4
  } stat_e;

  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] vale;
    logic [63:0] valm;
  } w_reg_t;

  localparam w_reg_t W_NOP = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    ra:    4'd0,
    rb:    4'd0,
    vale:  64'd0,
    valm:  64'd0
  };

  logic [7:0]    mem [MEM_BYTES];

  logic          is_read;
  logic          is_write;
  logic [63:0]   addr;
  logic [63:0]   wdata;
  logic [AW-1:0] base;
  logic          stat_ok;
  logic          addr_err;
  logic          mem_we;
  logic [63:0]   rdata;
  logic [63:0]   valm;
  logic [3:0]    stat;
  w_reg_t        w_d;
  w_reg_t        w_q;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch for the missing icodes.
  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = 64'd0;
    wdata    = 64'd0;
    case (bus.M_icode)
      I_RMMOVQ, I_PUSHQ: begin
        is_write = 1'b1;
        addr     = bus.M_valE;
        wdata    = bus.M_valA;
      end
      I_CALL: begin
        is_write = 1'b1;
        addr     = bus.M_valE;
        wdata    = bus.M_valP;
      end
      I_MRMOVQ: begin
        is_read = 1'b1;
        addr    = bus.M_valE;
      end
      I_RET, I_POPQ: begin
        is_read = 1'b1;
        addr    = bus.M_valA;
      end
      default: ;
    endcase
  end

  assign base    = addr[AW-1:0];
  assign stat_ok = (bus.M_stat == STAT_AOK);

  // The full 64-bit compare catches huge and wrapping addresses that the
  // truncated index alone would silently alias into the array.
  assign addr_err = stat_ok && (is_read || is_write) && (addr > ADDR_LIMIT);

  assign stat = addr_err ? STAT_ADR : bus.M_stat;

  // Reset gates the write so an access in flight during reset is dropped.
  assign mem_we = stat_ok && is_write && !addr_err && !bus.W_stall && rst_n;

  always_comb begin
    rdata = 64'd0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  assign valm = (stat_ok && is_read && !addr_err) ? rdata : 64'd0;

  // NOTE: the data array deliberately has no reset branch; clearing a RAM
  // cannot be done in one cycle and would block mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_d.stat  = stat;
    w_d.icode = bus.M_icode;
    w_d.cnd   = bus.M_Cnd;
    w_d.ra    = bus.M_rA;
    w_d.rb    = bus.M_rB;
    w_d.vale  = bus.M_valE;
    w_d.valm  = valm;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= W_NOP;
    end else if (bus.W_stall) begin
      w_q <= w_q;
    end else if (bus.W_bubble) begin
      w_q <= W_NOP;
    end else begin
      w_q <= w_d;
    end
  end

  assign bus.m_valM  = valm;
  assign bus.m_stat  = stat;
  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_Cnd   = w_q.cnd;
  assign bus.W_rA    = w_q.ra;
  assign bus.W_rB    = w_q.rb;
  assign bus.W_valE  = w_q.vale;
  assign bus.W_valM  = w_q.valm;

endmodule

// File: tb/tb_memory_stage_wreg.sv
// Directed bench for memory_stage_wreg: one task per feature, inline checks
// against hand-computed values, single summary line at the end.
module tb_memory_stage_wreg;

  localparam int MEM_BYTES = 1024;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  memory_stage_wreg_if mif ();

  memory_stage_wreg #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] stat, input logic [3:0] icode,
                       input logic cnd, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vale, input logic [63:0] vala,
                       input logic [63:0] valp);
    mif.M_stat  = stat;
    mif.M_icode = icode;
    mif.M_Cnd   = cnd;
    mif.M_rA    = ra;
    mif.M_rB    = rb;
    mif.M_valE  = vale;
    mif.M_valA  = vala;
    mif.M_valP  = valp;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    mif.W_stall  = 1'b0;
    mif.W_bubble = 1'b0;
    drive(4'd1, 4'd0, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mif.W_stat !== 4'd1) begin
      n_errors++;
      $display("FAIL reset_stat: got %0d expected 1", mif.W_stat);
    end
    n_checks++;
    if (mif.W_icode !== 4'd1) begin
      n_errors++;
      $display("FAIL reset_icode: got %0d expected 1", mif.W_icode);
    end
    n_checks++;
    if ({mif.W_Cnd, mif.W_rA, mif.W_rB, mif.W_valE, mif.W_valM} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got cnd=%0d ra=%0d rb=%0d vale=%h valm=%h expected all 0",
               mif.W_Cnd, mif.W_rA, mif.W_rB, mif.W_valE, mif.W_valM);
    end
  endtask

  task automatic test_store_load();
    tick();
    drive(4'd1, 4'd4, 1'b0, 4'd1, 4'd2, 64'h40, 64'h1122334455667788, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'd0 || mif.m_stat !== 4'd1) begin
      n_errors++;
      $display("FAIL store_comb: got valm=%h stat=%0d expected valm=0 stat=1", mif.m_valM, mif.m_stat);
    end
    tick();
    n_checks++;
    if (dut.mem[64] !== 8'h88) begin
      n_errors++;
      $display("FAIL store_byte40: got %h expected 88", dut.mem[64]);
    end
    n_checks++;
    if (mif.W_icode !== 4'd4 || mif.W_valE !== 64'h40 || mif.W_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL store_wreg: got icode=%0d vale=%h valm=%h expected 4/40/0",
               mif.W_icode, mif.W_valE, mif.W_valM);
    end
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd3, 64'h40, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'h1122334455667788) begin
      n_errors++;
      $display("FAIL load_comb: got %h expected 1122334455667788", mif.m_valM);
    end
    tick();
    n_checks++;
    if (mif.W_valM !== 64'h1122334455667788 || mif.W_icode !== 4'd5) begin
      n_errors++;
      $display("FAIL load_wreg: got valm=%h icode=%0d expected 1122334455667788/5",
               mif.W_valM, mif.W_icode);
    end
    drive(4'd1, 4'd4, 1'b0, 4'd0, 4'd0, 64'h48, 64'h99AABBCCDDEEFF00, 64'd0);
    tick();
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'h44, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'hDDEEFF0011223344) begin
      n_errors++;
      $display("FAIL load_unaligned: got %h expected ddeeff0011223344", mif.m_valM);
    end
    tick();
  endtask

  task automatic test_addr_error();
    drive(4'd1, 4'd4, 1'b0, 4'd0, 4'd0, 64'(MEM_BYTES - 8), 64'h0F0E0D0C0B0A0908, 64'd0);
    tick();
    n_checks++;
    if (mif.W_stat !== 4'd1) begin
      n_errors++;
      $display("FAIL adr_edge_store: got stat=%0d expected 1", mif.W_stat);
    end
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd1 || mif.m_valM !== 64'h0F0E0D0C0B0A0908) begin
      n_errors++;
      $display("FAIL adr_edge_load: got stat=%0d valm=%h expected 1/0f0e0d0c0b0a0908",
               mif.m_stat, mif.m_valM);
    end
    tick();
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'(MEM_BYTES - 7), 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd3 || mif.m_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL adr_load_comb: got stat=%0d valm=%h expected 3/0", mif.m_stat, mif.m_valM);
    end
    tick();
    n_checks++;
    if (mif.W_stat !== 4'd3 || mif.W_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL adr_load_wreg: got stat=%0d valm=%h expected 3/0", mif.W_stat, mif.W_valM);
    end
    drive(4'd1, 4'd4, 1'b0, 4'd0, 4'd0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd3) begin
      n_errors++;
      $display("FAIL adr_store_comb: got stat=%0d expected 3", mif.m_stat);
    end
    tick();
    n_checks++;
    if (mif.W_stat !== 4'd3 || mif.W_valE !== 64'hFFFFFFFFFFFFFFFC) begin
      n_errors++;
      $display("FAIL adr_store_wreg: got stat=%0d vale=%h expected 3/fffffffffffffffc",
               mif.W_stat, mif.W_valE);
    end
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'h0F0E0D0C0B0A0908) begin
      n_errors++;
      $display("FAIL adr_store_blocked: got %h expected 0f0e0d0c0b0a0908", mif.m_valM);
    end
    drive(4'd1, 4'd6, 1'b0, 4'd0, 4'd0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd1 || mif.m_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL adr_no_access: got stat=%0d valm=%h expected 1/0", mif.m_stat, mif.m_valM);
    end
    tick();
  endtask

  task automatic test_call_ret();
    drive(4'd1, 4'd8, 1'b0, 4'd0, 4'd4, 64'h100, 64'd0, 64'h2A);
    tick();
    drive(4'd1, 4'd9, 1'b0, 4'd0, 4'd4, 64'h108, 64'h100, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'h2A) begin
      n_errors++;
      $display("FAIL ret_comb: got %h expected 2a", mif.m_valM);
    end
    tick();
    n_checks++;
    if (mif.W_valM !== 64'h2A || mif.W_icode !== 4'd9) begin
      n_errors++;
      $display("FAIL ret_wreg: got valm=%h icode=%0d expected 2a/9", mif.W_valM, mif.W_icode);
    end
    drive(4'd1, 4'd11, 1'b0, 4'd2, 4'd4, 64'h108, 64'h100, 64'd0);
    tick();
    n_checks++;
    if (mif.W_valM !== 64'h2A || mif.W_icode !== 4'd11 || mif.W_rA !== 4'd2) begin
      n_errors++;
      $display("FAIL popq_wreg: got valm=%h icode=%0d ra=%0d expected 2a/11/2",
               mif.W_valM, mif.W_icode, mif.W_rA);
    end
  endtask

  task automatic test_stall_bubble();
    drive(4'd1, 4'd4, 1'b0, 4'd5, 4'd0, 64'h200, 64'h1234, 64'd0);
    tick();
    mif.W_stall = 1'b1;
    drive(4'd1, 4'd10, 1'b1, 4'd9, 4'd4, 64'h200, 64'hDEAD, 64'd0);
    tick();
    n_checks++;
    if (mif.W_icode !== 4'd4 || mif.W_rA !== 4'd5 || mif.W_Cnd !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_hold: got icode=%0d ra=%0d cnd=%0d expected 4/5/0",
               mif.W_icode, mif.W_rA, mif.W_Cnd);
    end
    mif.W_stall = 1'b0;
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'h200, 64'd0, 64'd0);
    tick();
    n_checks++;
    if (mif.W_valM !== 64'h1234 || mif.W_icode !== 4'd5) begin
      n_errors++;
      $display("FAIL stall_no_write: got valm=%h icode=%0d expected 1234/5", mif.W_valM, mif.W_icode);
    end
    mif.W_stall  = 1'b1;
    mif.W_bubble = 1'b1;
    drive(4'd1, 4'd6, 1'b1, 4'd1, 4'd1, 64'h7, 64'd0, 64'd0);
    tick();
    n_checks++;
    if (mif.W_icode !== 4'd5 || mif.W_valM !== 64'h1234) begin
      n_errors++;
      $display("FAIL stall_over_bubble: got icode=%0d valm=%h expected 5/1234", mif.W_icode, mif.W_valM);
    end
    mif.W_stall = 1'b0;
    tick();
    n_checks++;
    if (mif.W_icode !== 4'd1 || mif.W_stat !== 4'd1 ||
        {mif.W_Cnd, mif.W_rA, mif.W_rB, mif.W_valE, mif.W_valM} !== '0) begin
      n_errors++;
      $display("FAIL bubble: got icode=%0d stat=%0d vale=%h valm=%h expected 1/1/0/0",
               mif.W_icode, mif.W_stat, mif.W_valE, mif.W_valM);
    end
    mif.W_bubble = 1'b0;
  endtask

  task automatic test_non_aok();
    drive(4'd1, 4'd4, 1'b0, 4'd0, 4'd0, 64'h300, 64'hCAFEF00D, 64'd0);
    tick();
    drive(4'd4, 4'd4, 1'b1, 4'd3, 4'd7, 64'h300, 64'hBAD, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd4 || mif.m_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL ins_comb: got stat=%0d valm=%h expected 4/0", mif.m_stat, mif.m_valM);
    end
    tick();
    n_checks++;
    if (mif.W_stat !== 4'd4 || mif.W_rA !== 4'd3 || mif.W_rB !== 4'd7 || mif.W_Cnd !== 1'b1 ||
        mif.W_valE !== 64'h300 || mif.W_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL ins_wreg: got stat=%0d ra=%0d rb=%0d cnd=%0d vale=%h valm=%h expected 4/3/7/1/300/0",
               mif.W_stat, mif.W_rA, mif.W_rB, mif.W_Cnd, mif.W_valE, mif.W_valM);
    end
    drive(4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 64'h300, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd2 || mif.m_valM !== 64'd0) begin
      n_errors++;
      $display("FAIL hlt_no_read: got stat=%0d valm=%h expected 2/0", mif.m_stat, mif.m_valM);
    end
    drive(4'd2, 4'd5, 1'b0, 4'd0, 4'd0, 64'hFFFFFFFFFFFFFFF0, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_stat !== 4'd2) begin
      n_errors++;
      $display("FAIL hlt_over_adr: got stat=%0d expected 2", mif.m_stat);
    end
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'h300, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (mif.m_valM !== 64'hCAFEF00D) begin
      n_errors++;
      $display("FAIL ins_no_write: got %h expected cafef00d", mif.m_valM);
    end
    tick();
  endtask

  task automatic test_all_icodes();
    logic [63:0] exp_valm;
    mif.W_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(4'd1, 4'(i), 1'b0, 4'd0, 4'd0, 64'h40, 64'h40, 64'd0);
      #1;
      exp_valm = (i == 5 || i == 9 || i == 11) ? 64'h1122334455667788 : 64'd0;
      n_checks++;
      if (mif.m_stat !== 4'd1 || mif.m_valM !== exp_valm) begin
        n_errors++;
        $display("FAIL icode_%0d: got stat=%0d valm=%h expected 1/%h", i, mif.m_stat, mif.m_valM, exp_valm);
      end
    end
    mif.W_stall = 1'b0;
    drive(4'd1, 4'd0, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0);
    tick();
  endtask

  task automatic test_reset_midrun();
    drive(4'd1, 4'd4, 1'b0, 4'd0, 4'd0, 64'h80, 64'hAAAAAAAAAAAAAAAA, 64'd0);
    tick();
    drive(4'd1, 4'd5, 1'b1, 4'd2, 4'd3, 64'h40, 64'd0, 64'd0);
    tick();
    drive(4'd1, 4'd4, 1'b1, 4'd2, 4'd3, 64'h80, 64'h5555555555555555, 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mif.W_stat !== 4'd1 || mif.W_icode !== 4'd1 ||
        {mif.W_Cnd, mif.W_rA, mif.W_rB, mif.W_valE, mif.W_valM} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got stat=%0d icode=%0d cnd=%0d ra=%0d rb=%0d vale=%h valm=%h expected 1/1/0",
               mif.W_stat, mif.W_icode, mif.W_Cnd, mif.W_rA, mif.W_rB, mif.W_valE, mif.W_valM);
    end
    @(posedge clk);
    #3;
    drive(4'd1, 4'd5, 1'b0, 4'd0, 4'd0, 64'h80, 64'd0, 64'd0);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mif.m_valM !== 64'hAAAAAAAAAAAAAAAA) begin
      n_errors++;
      $display("FAIL reset_blocks_write: got %h expected aaaaaaaaaaaaaaaa", mif.m_valM);
    end
    tick();
    n_checks++;
    if (mif.W_valM !== 64'hAAAAAAAAAAAAAAAA || mif.W_icode !== 4'd5) begin
      n_errors++;
      $display("FAIL post_reset_load: got valm=%h icode=%0d expected aaaaaaaaaaaaaaaa/5",
               mif.W_valM, mif.W_icode);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_store_load();
    test_addr_error();
    test_call_ret();
    test_stall_bubble();
    test_non_aok();
    test_all_icodes();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
